// File: rtl/shift_unit_pkg.sv
// Shared constants and helpers for the shift unit.
package shift_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIST_W = 5;

  // Bidirectional-path direction encodings
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Mirror a word so a left shift can reuse the right-shift barrel
  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] value);
    logic [DATA_W-1:0] rev;
    rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rev[i] = value[DATA_W-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel stage: conditionally shift right by 2^K, filling with 'fill'.
module shift_stage
  import shift_unit_pkg::*;
#(
  parameter int unsigned K = 0
) (
  input  logic [DATA_W-1:0] data,
  input  logic              en,
  input  logic              fill,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned Amt = 1 << K;

  // Select between pass-through and the shifted word
  always_comb begin
    result = data;
    if (en) begin
      result = {{Amt{fill}}, data[DATA_W-1:Amt]};
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Combinational SLL/SRA and SRL barrel shifters with a one-cycle registered result.
module shift_unit
  import shift_unit_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  input  logic [DIST_W-1:0] distance,
  input  logic              direction,
  input  logic              sel_logical,
  output logic [DATA_W-1:0] ashift_out,
  output logic [DATA_W-1:0] lshift_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result
);

  logic              is_left;
  logic              a_fill;
  logic [DATA_W-1:0] a_chain [DIST_W+1];
  logic [DATA_W-1:0] l_chain [DIST_W+1];

  logic              out_valid_q;
  logic [DATA_W-1:0] out_result_q, out_result_d;

  assign is_left = (direction == DIR_LEFT);
  // Left shifts run through the right barrel on a mirrored word, so the fill must be zero
  assign a_fill  = is_left ? 1'b0 : data[DATA_W-1];

  // Prepare barrel inputs: mirrored word for left shifts, raw word otherwise
  always_comb begin
    a_chain[0] = is_left ? bit_reverse(data) : data;
    l_chain[0] = data;
  end

  for (genvar k = 0; k < DIST_W; k++) begin : g_stage
    shift_stage #(
      .K(k)
    ) u_a_stage (
      .data  (a_chain[k]),
      .en    (distance[k]),
      .fill  (a_fill),
      .result(a_chain[k+1])
    );

    shift_stage #(
      .K(k)
    ) u_l_stage (
      .data  (l_chain[k]),
      .en    (distance[k]),
      .fill  (1'b0),
      .result(l_chain[k+1])
    );
  end

  // Undo the mirroring for left shifts and drive the combinational outputs
  always_comb begin
    ashift_out = is_left ? bit_reverse(a_chain[DIST_W]) : a_chain[DIST_W];
    lshift_out = l_chain[DIST_W];
  end

  // Pick the path to capture; hold the old value when no operand is presented
  always_comb begin
    out_result_d = out_result_q;
    if (in_valid) begin
      out_result_d = sel_logical ? lshift_out : ashift_out;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      out_valid_q  <= in_valid;
      out_result_q <= out_result_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed and random self-checking bench for shift_unit.
module tb_shift_unit;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] data;
  logic [4:0]  distance;
  logic        direction;
  logic        sel_logical;
  logic [31:0] ashift_out;
  logic [31:0] lshift_out;
  logic        out_valid;
  logic [31:0] out_result;

  int checks = 0;
  int errors = 0;

  shift_unit u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .data       (data),
    .distance   (distance),
    .direction  (direction),
    .sel_logical(sel_logical),
    .ashift_out (ashift_out),
    .lshift_out (lshift_out),
    .out_valid  (out_valid),
    .out_result (out_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference shift semantics
  function automatic logic [31:0] ref_sll(input logic [31:0] d, input logic [4:0] s);
    return d << s;
  endfunction
  function automatic logic [31:0] ref_srl(input logic [31:0] d, input logic [4:0] s);
    return d >> s;
  endfunction
  function automatic logic [31:0] ref_sra(input logic [31:0] d, input logic [4:0] s);
    return $unsigned($signed(d) >>> s);
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                       input logic dir, input logic sel);
    in_valid    = v;
    data        = d;
    distance    = s;
    direction   = dir;
    sel_logical = sel;
  endtask

  logic [31:0] exp_res;
  logic [31:0] held;
  logic [31:0] ops [3];
  logic [4:0]  dists [3];
  logic        dirs [3];
  logic        sels [3];

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    check("reset_result", out_result, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic left shift and registered capture
    drive(1'b1, 32'h0000_0001, 5'd4, 1'b0, 1'b0);
    #1;
    check("sll1_comb", ashift_out, 32'h0000_0010);
    @(posedge clock); #1;
    check("sll1_valid", {31'b0, out_valid}, 32'h1);
    check("sll1_result", out_result, 32'h0000_0010);

    // Arithmetic vs logical right
    @(negedge clock);
    drive(1'b0, 32'h8000_0000, 5'd4, 1'b1, 1'b0);
    #1;
    check("sra_msb", ashift_out, 32'hF800_0000);
    check("srl_msb", lshift_out, 32'h0800_0000);

    // Distance boundaries
    drive(1'b0, 32'h8765_4321, 5'd0, 1'b0, 1'b0);
    #1;
    check("d0_left", ashift_out, 32'h8765_4321);
    check("d0_srl", lshift_out, 32'h8765_4321);
    direction = 1'b1; #1;
    check("d0_sra", ashift_out, 32'h8765_4321);
    distance = 5'd31; #1;
    check("d31_sra", ashift_out, 32'hFFFF_FFFF);
    check("d31_srl", lshift_out, 32'h0000_0001);
    direction = 1'b0; #1;
    check("d31_sll", ashift_out, 32'h8000_0000);
    check("hold_while_idle", out_result, 32'h0000_0010);

    // Three back-to-back operands
    ops[0] = 32'hDEAD_BEEF; dists[0] = 5'd8;  dirs[0] = 1'b1; sels[0] = 1'b0;
    ops[1] = 32'h1234_5678; dists[1] = 5'd12; dirs[1] = 1'b0; sels[1] = 1'b0;
    ops[2] = 32'hF0F0_0F0F; dists[2] = 5'd3;  dirs[2] = 1'b1; sels[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1'b1, ops[i], dists[i], dirs[i], sels[i]);
      if (sels[i]) exp_res = ref_srl(ops[i], dists[i]);
      else if (dirs[i]) exp_res = ref_sra(ops[i], dists[i]);
      else exp_res = ref_sll(ops[i], dists[i]);
      @(posedge clock); #1;
      check($sformatf("b2b%0d_valid", i), {31'b0, out_valid}, 32'h1);
      check($sformatf("b2b%0d_result", i), out_result, exp_res);
    end
    held = exp_res;
    @(negedge clock);
    in_valid = 1'b0;
    data = 'x; distance = 'x; direction = 'x; sel_logical = 'x;
    @(posedge clock); #1;
    check("idle_valid", {31'b0, out_valid}, 32'h0);
    check("idle_hold", out_result, held);

    // Asynchronous reset mid-stream with a valid operand pending
    @(negedge clock);
    drive(1'b1, 32'hAAAA_5555, 5'd1, 1'b0, 1'b0);
    @(posedge clock); #1;
    check("pre_reset", out_result, 32'h5554_AAAA);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    check("async_rst_result", out_result, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("post_rst_valid", {31'b0, out_valid}, 32'h0);
    check("post_rst_result", out_result, 32'h0);
    @(negedge clock);
    drive(1'b1, 32'h0000_00FF, 5'd4, 1'b1, 1'b1);
    @(posedge clock); #1;
    check("first_op_valid", {31'b0, out_valid}, 32'h1);
    check("first_op_result", out_result, 32'h0000_000F);

    // Random vectors against reference semantics
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      held = out_result;
      #1;
      check("rnd_ashift", ashift_out,
            direction ? ref_sra(data, distance) : ref_sll(data, distance));
      check("rnd_lshift", lshift_out, ref_srl(data, distance));
      if (!in_valid) exp_res = held;
      else if (sel_logical) exp_res = ref_srl(data, distance);
      else if (direction) exp_res = ref_sra(data, distance);
      else exp_res = ref_sll(data, distance);
      @(posedge clock); #1;
      check("rnd_valid", {31'b0, out_valid}, {31'b0, in_valid});
      check("rnd_result", out_result, exp_res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
